// File: rtl/core_decode_stage.sv
// Instruction decode stage: RV32/64 base + optional F and custom opcodes, decoded into a
// two-entry (output + skid) elastic buffer with flush and an illegal-instruction counter.
module core_decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter bit          FPU_EN    = 1'b1,
  parameter bit          CUSTOM_EN = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     IN_INST,
  input  logic [XLEN-1:0] IN_PC,
  input  logic            FLUSH,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_PC,
  output logic [XLEN-1:0] OUT_IMM,
  output logic [5:0]      OUT_RD,
  output logic [5:0]      OUT_RS1,
  output logic [5:0]      OUT_RS2,
  output logic [3:0]      OUT_CLASS,
  output logic [2:0]      OUT_FUNC3,
  output logic [6:0]      OUT_FUNC7,
  output logic            OUT_ILLEGAL,
  output logic [15:0]     ILL_CNT
);

  localparam logic [3:0] ClsOpImm  = 4'd0;
  localparam logic [3:0] ClsOp     = 4'd1;
  localparam logic [3:0] ClsBranch = 4'd2;
  localparam logic [3:0] ClsLoad   = 4'd3;
  localparam logic [3:0] ClsStore  = 4'd4;
  localparam logic [3:0] ClsJal    = 4'd5;
  localparam logic [3:0] ClsJalr   = 4'd6;
  localparam logic [3:0] ClsLui    = 4'd7;
  localparam logic [3:0] ClsAuipc  = 4'd8;
  localparam logic [3:0] ClsFlw    = 4'd9;
  localparam logic [3:0] ClsFsw    = 4'd10;
  localparam logic [3:0] ClsOpFp   = 4'd11;
  localparam logic [3:0] ClsCustom = 4'd12;
  localparam logic [3:0] ClsIll    = 4'd15;

  typedef enum logic [2:0] {FmtNone, FmtI, FmtS, FmtB, FmtU, FmtJ} fmt_e;
  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [5:0]      rd;
    logic [5:0]      rs1;
    logic [5:0]      rs2;
    logic [3:0]      cls;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic            illegal;
  } dec_t;

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [6:0]  w_sh_f7;
  logic [31:0] w_imm32;
  logic [3:0]  w_cls;
  fmt_e        w_fmt;
  logic        w_bad;
  logic        w_use_rd, w_use_rs1, w_use_rs2;
  logic        w_fp_rd, w_fp_rs1, w_fp_rs2;
  dec_t        w_dec;

  assign w_op = IN_INST[6:0];
  assign w_f3 = IN_INST[14:12];
  assign w_f7 = IN_INST[31:25];
  // RV64 shifts use bit 25 as shamt[5], so only the upper six bits act as func7.
  assign w_sh_f7 = (XLEN == 64) ? {IN_INST[31:26], 1'b0} : IN_INST[31:25];

  always_comb begin
    w_cls     = ClsIll;
    w_fmt     = FmtNone;
    w_bad     = 1'b0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_fp_rd   = 1'b0;
    w_fp_rs1  = 1'b0;
    w_fp_rs2  = 1'b0;
    // Only the IN/OUT custom opcode lacks 2'b11 in bits 1:0; anything else falls to default.
    case (w_op)
      7'b0010011: begin
        w_cls = ClsOpImm; w_fmt = FmtI; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
        w_bad = (w_f3 == 3'b101) && (w_sh_f7 != 7'b0000000) && (w_sh_f7 != 7'b0100000);
      end
      7'b0110011: begin
        w_cls = ClsOp; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        if (w_f7 == 7'b0100000)      w_bad = (w_f3 != 3'b000) && (w_f3 != 3'b101);
        else if (w_f7 != 7'b0000000) w_bad = 1'b1;
      end
      7'b1100011: begin
        w_cls = ClsBranch; w_fmt = FmtB; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_bad = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      7'b0000011: begin
        w_cls = ClsLoad; w_fmt = FmtI; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
        w_bad = (w_f3 == 3'b111) || (((w_f3 == 3'b011) || (w_f3 == 3'b110)) && (XLEN != 64));
      end
      7'b0100011: begin
        w_cls = ClsStore; w_fmt = FmtS; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_bad = w_f3[2] || ((w_f3 == 3'b011) && (XLEN != 64));
      end
      7'b1101111: begin w_cls = ClsJal;   w_fmt = FmtJ; w_use_rd = 1'b1; end
      7'b1100111: begin w_cls = ClsJalr;  w_fmt = FmtI; w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
      7'b0110111: begin w_cls = ClsLui;   w_fmt = FmtU; w_use_rd = 1'b1; end
      7'b0010111: begin w_cls = ClsAuipc; w_fmt = FmtU; w_use_rd = 1'b1; end
      7'b0000111: begin
        w_cls = ClsFlw; w_fmt = FmtI; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_fp_rd = 1'b1;
        w_bad = !FPU_EN;
      end
      7'b0100111: begin
        w_cls = ClsFsw; w_fmt = FmtS; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_fp_rs2 = 1'b1;
        w_bad = !FPU_EN;
      end
      7'b1010011: begin
        w_cls = ClsOpFp; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_fp_rd = 1'b1; w_fp_rs1 = 1'b1; w_fp_rs2 = 1'b1;
        w_bad = !FPU_EN;
        case (w_f7)
          7'b1010000: w_fp_rd = 1'b0;
          7'b1100000: begin w_fp_rd = 1'b0; w_use_rs2 = 1'b0; end
          7'b1101000, 7'b1111000: begin w_fp_rs1 = 1'b0; w_use_rs2 = 1'b0; end
          7'b1110000, 7'b0101100: w_use_rs2 = 1'b0;
          default: ;
        endcase
      end
      7'b0001011, 7'b0000001: begin
        w_cls = ClsCustom; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_bad = !CUSTOM_EN;
      end
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_imm32 = '0;
    unique case (w_fmt)
      FmtI:    w_imm32 = {{20{IN_INST[31]}}, IN_INST[31:20]};
      FmtS:    w_imm32 = {{20{IN_INST[31]}}, IN_INST[31:25], IN_INST[11:7]};
      FmtB:    w_imm32 = {{19{IN_INST[31]}}, IN_INST[31], IN_INST[7], IN_INST[30:25],
                          IN_INST[11:8], 1'b0};
      FmtU:    w_imm32 = {IN_INST[31:12], 12'b0};
      FmtJ:    w_imm32 = {{11{IN_INST[31]}}, IN_INST[31], IN_INST[19:12], IN_INST[20],
                          IN_INST[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  always_comb begin
    w_dec         = '0;
    w_dec.pc      = IN_PC;
    w_dec.func3   = w_f3;
    w_dec.func7   = w_f7;
    w_dec.illegal = w_bad;
    w_dec.cls     = w_bad ? ClsIll : w_cls;
    if (!w_bad) begin
      w_dec.imm = XLEN'($signed(w_imm32));
      if (w_use_rd)  w_dec.rd  = {w_fp_rd,  IN_INST[11:7]};
      if (w_use_rs1) w_dec.rs1 = {w_fp_rs1, IN_INST[19:15]};
      if (w_use_rs2) w_dec.rs2 = {w_fp_rs2, IN_INST[24:20]};
    end
  end

  state_e      r_state;
  dec_t        r_out, r_skid;
  logic        r_out_valid, r_in_ready;
  logic [15:0] r_ill_cnt;
  logic        w_accept, w_drain;

  assign w_accept = IN_VALID && r_in_ready;
  assign w_drain  = r_out_valid && OUT_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= StEmpty;
      r_out       <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_ill_cnt   <= '0;
    end else if (FLUSH) begin
      r_state     <= StEmpty;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      if (w_accept && w_dec.illegal && (r_ill_cnt != 16'hFFFF)) r_ill_cnt <= r_ill_cnt + 16'd1;
      unique case (r_state)
        StEmpty: begin
          if (w_accept) begin
            r_out       <= w_dec;
            r_out_valid <= 1'b1;
            r_state     <= StOne;
          end
        end
        StOne: begin
          if (w_accept && !w_drain) begin
            r_skid     <= w_dec;
            r_in_ready <= 1'b0;
            r_state    <= StTwo;
          end else if (w_accept) begin
            r_out <= w_dec;
          end else if (w_drain) begin
            r_out_valid <= 1'b0;
            r_state     <= StEmpty;
          end
        end
        StTwo: begin
          if (w_drain) begin
            r_out      <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= StOne;
          end
        end
        default: r_state <= StEmpty;
      endcase
    end
  end

  assign IN_READY    = r_in_ready;
  assign OUT_VALID   = r_out_valid;
  assign OUT_PC      = r_out.pc;
  assign OUT_IMM     = r_out.imm;
  assign OUT_RD      = r_out.rd;
  assign OUT_RS1     = r_out.rs1;
  assign OUT_RS2     = r_out.rs2;
  assign OUT_CLASS   = r_out.cls;
  assign OUT_FUNC3   = r_out.func3;
  assign OUT_FUNC7   = r_out.func7;
  assign OUT_ILLEGAL = r_out.illegal;
  assign ILL_CNT     = r_ill_cnt;

endmodule

// File: tb/tb_core_decode_stage.sv
// Bench for core_decode_stage: decode vector table on a full-featured RV32 instance and an
// RV64 instance with FPU/custom disabled, plus backpressure, flush, async reset, saturation.
module tb_core_decode_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0, IN_READY, FLUSH = 1'b0, OUT_VALID, OUT_READY = 1'b1;
  logic [31:0] IN_INST = '0, IN_PC = '0, OUT_PC, OUT_IMM;
  logic [5:0]  OUT_RD, OUT_RS1, OUT_RS2;
  logic [3:0]  OUT_CLASS;
  logic [2:0]  OUT_FUNC3;
  logic [6:0]  OUT_FUNC7;
  logic        OUT_ILLEGAL;
  logic [15:0] ILL_CNT;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid;
  logic [31:0] b_in_inst = '0;
  logic [63:0] b_in_pc = '0, b_out_pc, b_out_imm;
  logic [5:0]  b_out_rd, b_out_rs1, b_out_rs2;
  logic [3:0]  b_out_class;
  logic [2:0]  b_out_func3;
  logic [6:0]  b_out_func7;
  logic        b_out_illegal;
  logic [15:0] b_ill_cnt;

  always #5 CLK = ~CLK;

  core_decode_stage #(.XLEN(32), .FPU_EN(1'b1), .CUSTOM_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INST(IN_INST),
    .IN_PC(IN_PC), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_PC(OUT_PC), .OUT_IMM(OUT_IMM), .OUT_RD(OUT_RD), .OUT_RS1(OUT_RS1), .OUT_RS2(OUT_RS2),
    .OUT_CLASS(OUT_CLASS), .OUT_FUNC3(OUT_FUNC3), .OUT_FUNC7(OUT_FUNC7),
    .OUT_ILLEGAL(OUT_ILLEGAL), .ILL_CNT(ILL_CNT)
  );

  core_decode_stage #(.XLEN(64), .FPU_EN(1'b0), .CUSTOM_EN(1'b0)) dut64 (
    .CLK(CLK), .RST(RST), .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .IN_INST(b_in_inst),
    .IN_PC(b_in_pc), .FLUSH(1'b0), .OUT_VALID(b_out_valid), .OUT_READY(1'b1),
    .OUT_PC(b_out_pc), .OUT_IMM(b_out_imm), .OUT_RD(b_out_rd), .OUT_RS1(b_out_rs1),
    .OUT_RS2(b_out_rs2), .OUT_CLASS(b_out_class), .OUT_FUNC3(b_out_func3),
    .OUT_FUNC7(b_out_func7), .OUT_ILLEGAL(b_out_illegal), .ILL_CNT(b_ill_cnt)
  );

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  cls;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  localparam int NV = 24;
  localparam int NB = 6;
  vec_t        vecs[NV];
  vec_t        bvecs[NB];
  int          checks = 0;
  int          errors = 0;
  int          exp_ill = 0;
  bit          rec = 1'b0;
  logic [31:0] got[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge, so the DUT sees them stable at the next edge.
  task automatic step();
    if (rec && OUT_VALID && OUT_READY) got.push_back(OUT_PC);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'hFFF00093, 4'd0,  6'h01, 6'h00, 6'h00, 64'hFFFFFFFF, 1'b0};
    vecs[1]  = '{32'h002081B3, 4'd1,  6'h03, 6'h01, 6'h02, 64'h0,        1'b0};
    vecs[2]  = '{32'h402081B3, 4'd1,  6'h03, 6'h01, 6'h02, 64'h0,        1'b0};
    vecs[3]  = '{32'h402091B3, 4'd15, 6'h00, 6'h00, 6'h00, 64'h0,        1'b1};
    vecs[4]  = '{32'h022081B3, 4'd15, 6'h00, 6'h00, 6'h00, 64'h0,        1'b1};
    vecs[5]  = '{32'hFE000EE3, 4'd2,  6'h00, 6'h00, 6'h00, 64'hFFFFFFFC, 1'b0};
    vecs[6]  = '{32'h00002063, 4'd15, 6'h00, 6'h00, 6'h00, 64'h0,        1'b1};
    vecs[7]  = '{32'h00812283, 4'd3,  6'h05, 6'h02, 6'h00, 64'h8,        1'b0};
    vecs[8]  = '{32'h00813283, 4'd15, 6'h00, 6'h00, 6'h00, 64'h0,        1'b1};
    vecs[9]  = '{32'hFE512E23, 4'd4,  6'h00, 6'h02, 6'h05, 64'hFFFFFFFC, 1'b0};
    vecs[10] = '{32'hFF9FF0EF, 4'd5,  6'h01, 6'h00, 6'h00, 64'hFFFFFFF8, 1'b0};
    vecs[11] = '{32'h123453B7, 4'd7,  6'h07, 6'h00, 6'h00, 64'h12345000, 1'b0};
    vecs[12] = '{32'h80000117, 4'd8,  6'h02, 6'h00, 6'h00, 64'h80000000, 1'b0};
    vecs[13] = '{32'h00008067, 4'd6,  6'h00, 6'h01, 6'h00, 64'h0,        1'b0};
    vecs[14] = '{32'h4030D093, 4'd0,  6'h01, 6'h01, 6'h00, 64'h403,      1'b0};
    vecs[15] = '{32'h4230D093, 4'd15, 6'h00, 6'h00, 6'h00, 64'h0,        1'b1};
    vecs[16] = '{32'h00412187, 4'd9,  6'h23, 6'h02, 6'h00, 64'h4,        1'b0};
    vecs[17] = '{32'h00512427, 4'd10, 6'h00, 6'h02, 6'h25, 64'h8,        1'b0};
    vecs[18] = '{32'h002081D3, 4'd11, 6'h23, 6'h21, 6'h22, 64'h0,        1'b0};
    vecs[19] = '{32'hA020A1D3, 4'd11, 6'h03, 6'h21, 6'h22, 64'h0,        1'b0};
    vecs[20] = '{32'hD00081D3, 4'd11, 6'h23, 6'h01, 6'h00, 64'h0,        1'b0};
    vecs[21] = '{32'h0020818B, 4'd12, 6'h03, 6'h01, 6'h02, 64'h0,        1'b0};
    vecs[22] = '{32'hFFF00090, 4'd15, 6'h00, 6'h00, 6'h00, 64'h0,        1'b1};
    vecs[23] = '{32'h0000007F, 4'd15, 6'h00, 6'h00, 6'h00, 64'h0,        1'b1};

    bvecs[0] = '{32'hFFF00093, 4'd0,  6'h01, 6'h00, 6'h00, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    bvecs[1] = '{32'h002081D3, 4'd15, 6'h00, 6'h00, 6'h00, 64'h0,                1'b1};
    bvecs[2] = '{32'h00813283, 4'd3,  6'h05, 6'h02, 6'h00, 64'h8,                1'b0};
    bvecs[3] = '{32'h0020818B, 4'd15, 6'h00, 6'h00, 6'h00, 64'h0,                1'b1};
    bvecs[4] = '{32'h800003B7, 4'd7,  6'h07, 6'h00, 6'h00, 64'hFFFFFFFF80000000, 1'b0};
    bvecs[5] = '{32'h4210D093, 4'd0,  6'h01, 6'h01, 6'h00, 64'h421,              1'b0};

    // Reset state
    repeat (2) @(posedge CLK);
    #3 RST = 1'b0;
    step();
    chk("rst.out_valid", OUT_VALID, 0);
    chk("rst.in_ready", IN_READY, 1);
    chk("rst.ill_cnt", ILL_CNT, 0);
    chk("rst.class", OUT_CLASS, 0);
    chk("rst.imm", OUT_IMM, 0);

    // Decode table, one instruction per cycle with the sink always ready
    for (int i = 0; i < NV; i++) begin
      IN_VALID = 1'b1;
      IN_INST  = vecs[i].inst;
      IN_PC    = 32'h1000 + 32'(i * 4);
      step();
      IN_VALID = 1'b0;
      if (vecs[i].ill) exp_ill++;
      chk($sformatf("v%0d.valid", i), OUT_VALID, 1);
      chk($sformatf("v%0d.pc", i), OUT_PC, 32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d.class", i), OUT_CLASS, vecs[i].cls);
      chk($sformatf("v%0d.rd", i), OUT_RD, vecs[i].rd);
      chk($sformatf("v%0d.rs1", i), OUT_RS1, vecs[i].rs1);
      chk($sformatf("v%0d.rs2", i), OUT_RS2, vecs[i].rs2);
      chk($sformatf("v%0d.imm", i), {32'h0, OUT_IMM}, vecs[i].imm);
      chk($sformatf("v%0d.illegal", i), OUT_ILLEGAL, vecs[i].ill);
      if (!vecs[i].ill) begin
        chk($sformatf("v%0d.func3", i), OUT_FUNC3, {61'h0, vecs[i].inst[14:12]});
        chk($sformatf("v%0d.func7", i), OUT_FUNC7, {57'h0, vecs[i].inst[31:25]});
      end
    end
    step();
    chk("table.drained", OUT_VALID, 0);
    chk("table.ill_cnt", ILL_CNT, 64'(exp_ill));

    // Backpressure: two held, third stalls, then in-order drain
    got.delete();
    rec = 1'b1;
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; IN_INST = 32'h00100093; IN_PC = 32'h100;
    step();
    chk("bp.ready_after1", IN_READY, 1);
    IN_INST = 32'h00200093; IN_PC = 32'h104;
    step();
    chk("bp.ready_after2", IN_READY, 0);
    chk("bp.pc_held", OUT_PC, 32'h100);
    IN_INST = 32'h00300093; IN_PC = 32'h108;
    repeat (2) step();
    chk("bp.stall_ready", IN_READY, 0);
    chk("bp.stall_pc", OUT_PC, 32'h100);
    chk("bp.stall_imm", OUT_IMM, 32'h1);
    OUT_READY = 1'b1;
    step();
    chk("bp.skid_moved", OUT_PC, 32'h104);
    chk("bp.ready_back", IN_READY, 1);
    step();
    IN_VALID = 1'b0;
    chk("bp.third_pc", OUT_PC, 32'h108);
    step();
    chk("bp.empty", OUT_VALID, 0);
    rec = 1'b0;
    chk("bp.count", 64'(got.size()), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) chk($sformatf("bp.order%0d", i), got[i], 32'h100 + 32'(i * 4));
    end

    // Flush from TWO with a valid request pending
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; IN_INST = 32'h00100093; IN_PC = 32'h200;
    step();
    IN_INST = 32'h0000007F; IN_PC = 32'h204;
    step();
    exp_ill++;
    chk("fl.in_two", IN_READY, 0);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("fl.two_valid", OUT_VALID, 0);
    chk("fl.two_ready", IN_READY, 1);
    chk("fl.two_ill", ILL_CNT, 64'(exp_ill));
    // Flush in ONE drops a simultaneously accepted illegal instruction
    IN_INST = 32'h00100093; IN_PC = 32'h300;
    step();
    IN_INST = 32'h0000007F;
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    chk("fl.one_valid", OUT_VALID, 0);
    chk("fl.one_ill", ILL_CNT, 64'(exp_ill));
    step();
    chk("fl.stays_empty", OUT_VALID, 0);

    // Asynchronous reset while in TWO
    IN_VALID = 1'b1; IN_INST = 32'hFFF00093; IN_PC = 32'h400;
    step();
    IN_INST = 32'h0000007F; IN_PC = 32'h404;
    step();
    chk("ar.in_two", IN_READY, 0);
    #2;
    RST = 1'b1;
    IN_VALID = 1'b0;
    #1;
    chk("ar.valid", OUT_VALID, 0);
    chk("ar.ready", IN_READY, 1);
    chk("ar.pc", OUT_PC, 0);
    chk("ar.imm", OUT_IMM, 0);
    chk("ar.class", OUT_CLASS, 0);
    chk("ar.ill", ILL_CNT, 0);
    #3 RST = 1'b0;
    OUT_READY = 1'b1;

    // RV64 instance with FPU and custom opcodes disabled
    exp_ill = 0;
    for (int i = 0; i < NB; i++) begin
      b_in_valid = 1'b1;
      b_in_inst  = bvecs[i].inst;
      b_in_pc    = 64'h8000_0000_0000_0000 + 64'(i * 4);
      step();
      b_in_valid = 1'b0;
      if (bvecs[i].ill) exp_ill++;
      chk($sformatf("b%0d.valid", i), b_out_valid, 1);
      chk($sformatf("b%0d.pc", i), b_out_pc, 64'h8000_0000_0000_0000 + 64'(i * 4));
      chk($sformatf("b%0d.class", i), b_out_class, bvecs[i].cls);
      chk($sformatf("b%0d.rd", i), b_out_rd, bvecs[i].rd);
      chk($sformatf("b%0d.rs1", i), b_out_rs1, bvecs[i].rs1);
      chk($sformatf("b%0d.rs2", i), b_out_rs2, bvecs[i].rs2);
      chk($sformatf("b%0d.imm", i), b_out_imm, bvecs[i].imm);
      chk($sformatf("b%0d.illegal", i), b_out_illegal, bvecs[i].ill);
      chk($sformatf("b%0d.ill_cnt", i), b_ill_cnt, 64'(exp_ill));
    end
    step();

    // Saturation of the illegal counter
    chk("sat.start", ILL_CNT, 0);
    IN_VALID = 1'b1; IN_INST = 32'h0000007F; IN_PC = 32'h500;
    repeat (65534) step();
    chk("sat.fffe", ILL_CNT, 16'hFFFE);
    step();
    chk("sat.ffff", ILL_CNT, 16'hFFFF);
    repeat (5) step();
    chk("sat.hold", ILL_CNT, 16'hFFFF);
    chk("sat.class", OUT_CLASS, 15);
    IN_VALID = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
